// File: rtl/pci_initiator.sv
// pci_initiator: single-burst PCI bus master with a staged write buffer
module pci_initiator #(
  parameter int         BUF_DEPTH      = 8,
  parameter int         DEVSEL_TIMEOUT = 5,
  parameter int         TRDY_TIMEOUT   = 16,
  parameter logic [3:0] CMD_READ       = 4'b0110,
  parameter logic [3:0] CMD_WRITE      = 4'b0111
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_len,
  input  logic [3:0]  req_be,
  input  logic        wr_push,
  input  logic [31:0] wr_data,
  output logic        wr_full,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        done,
  output logic [1:0]  status,
  output logic [3:0]  words_done,
  inout  wire  [31:0] AD,
  output logic [3:0]  CBEout,
  output logic        frameout,
  output logic        IRDY,
  input  logic        TRDY,
  input  logic        DEVSEL,
  input  logic        stop
);
  localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int DW = $clog2(DEVSEL_TIMEOUT + 1);
  localparam int TW = $clog2(TRDY_TIMEOUT + 1);
  typedef enum logic [1:0] {IDLE, ADDR, DATA, END_S} state_t;
  state_t        state;
  logic [31:0]   mem [BUF_DEPTH];
  logic [CW-1:0] wr_count;
  logic [AW-1:0] rd_ptr;
  logic          write_q;
  logic [3:0]    be_q;
  logic [3:0]    remaining;
  logic          ad_oe;
  logic [31:0]   ad_q;
  logic [DW-1:0] dev_cnt;
  logic          dev_seen;
  logic [TW-1:0] trdy_cnt;
  logic          phase_ok, last_phase, stop_hit, dev_abort, trdy_abort, fin;
  logic [1:0]    fin_status;
  assign AD        = ad_oe ? ad_q : 'z;
  assign wr_full   = wr_count == CW'(BUF_DEPTH);
  assign req_ready = reset && state == IDLE && req_len != 4'd0 &&
                     (!req_write || 32'(wr_count) >= 32'(req_len));
  // Data-phase outcome for this edge; a completed phase outranks stop, stop outranks timeouts
  always_comb begin
    phase_ok   = state == DATA && !IRDY && !TRDY && !DEVSEL;
    last_phase = phase_ok && remaining == 4'd1;
    stop_hit   = state == DATA && !stop && !DEVSEL;
    dev_abort  = state == DATA && DEVSEL && !dev_seen && dev_cnt == DW'(DEVSEL_TIMEOUT - 1);
    trdy_abort = state == DATA && !DEVSEL && TRDY && trdy_cnt == TW'(TRDY_TIMEOUT - 1);
    fin        = last_phase || stop_hit || dev_abort || trdy_abort;
    fin_status = last_phase ? 2'b00 : stop_hit ? 2'b10 : dev_abort ? 2'b01 : 2'b11;
  end
  // Stage write words while idle; pushes when full or busy are dropped
  always_ff @(posedge clock)
    if (state == IDLE && wr_push && !wr_full) mem[wr_count[AW-1:0]] <= wr_data;
  // Bus FSM with registered bus drives and completion reporting
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      frameout   <= 1'b1;
      IRDY       <= 1'b1;
      CBEout     <= 4'd0;
      ad_oe      <= 1'b0;
      ad_q       <= 32'd0;
      write_q    <= 1'b0;
      be_q       <= 4'd0;
      remaining  <= 4'd0;
      wr_count   <= '0;
      rd_ptr     <= '0;
      dev_cnt    <= '0;
      dev_seen   <= 1'b0;
      trdy_cnt   <= '0;
      words_done <= 4'd0;
      status     <= 2'b00;
      done       <= 1'b0;
      rd_valid   <= 1'b0;
      rd_data    <= 32'd0;
    end else begin
      done     <= 1'b0;
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_push && !wr_full) wr_count <= wr_count + CW'(1);
          if (req_valid && req_ready) begin
            state      <= ADDR;
            write_q    <= req_write;
            be_q       <= req_be;
            remaining  <= req_len;
            words_done <= 4'd0;
            rd_ptr     <= '0;
            dev_cnt    <= '0;
            frameout   <= 1'b0;
            IRDY       <= 1'b1;
            CBEout     <= req_write ? CMD_WRITE : CMD_READ;
            ad_oe      <= 1'b1;
            ad_q       <= req_addr;
          end
        end
        ADDR: begin
          state    <= DATA;
          IRDY     <= 1'b0;
          CBEout   <= be_q;
          frameout <= remaining == 4'd1;
          ad_oe    <= write_q;
          ad_q     <= mem[rd_ptr];
          dev_cnt  <= dev_cnt + DW'(1);
          dev_seen <= 1'b0;
          trdy_cnt <= '0;
        end
        DATA: begin
          dev_cnt  <= dev_cnt + DW'(1);
          trdy_cnt <= (!DEVSEL && TRDY) ? trdy_cnt + TW'(1) : '0;
          if (!DEVSEL) dev_seen <= 1'b1;
          if (phase_ok) begin
            words_done <= words_done + 4'd1;
            remaining  <= remaining - 4'd1;
            rd_ptr     <= rd_ptr + AW'(1);
            ad_q       <= mem[rd_ptr + AW'(1)];
            frameout   <= remaining <= 4'd2;
            if (!write_q) begin
              rd_data  <= AD;
              rd_valid <= 1'b1;
            end
          end
          if (fin) begin
            state    <= END_S;
            frameout <= 1'b1;
            IRDY     <= 1'b1;
            CBEout   <= 4'd0;
            ad_oe    <= 1'b0;
            done     <= 1'b1;
            status   <= fin_status;
          end
        end
        default: begin
          state    <= IDLE;
          wr_count <= '0;
          rd_ptr   <= '0;
        end
      endcase
    end
  end
endmodule

// File: doc/pci_initiator.md
Name: pci_initiator

Overview:
- Bus master that sits directly upstream of the PCI target.
- Accepts a single-burst read or write request from local logic and runs the address phase on the shared bus.
- Drives frameout/IRDY/CBEout/AD and completes data phases against the target's TRDY/DEVSEL/stop.
- Returns read data and a completion status.
- Write data is staged in a small internal buffer before the request is issued.

Parameters:
- BUF_DEPTH, 8: write-buffer entries and max burst length.
- DEVSEL_TIMEOUT, 5: clocks after the address phase to wait for DEVSEL before master abort.
- TRDY_TIMEOUT, 16: clocks with DEVSEL low and no TRDY before abort.
- CMD_READ, 4'b0110: CBE command for a read.
- CMD_WRITE, 4'b0111: CBE command for a write.

Ports:
- clock  in  1  bus clock; all state changes on posedge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request strobe.
- req_ready  out  1  request can be accepted this cycle.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  address driven in the address phase.
- req_len  in  4  words in the burst, 1..BUF_DEPTH.
- req_be  in  4  data-phase CBE value; 4'b1111 = all lanes.
- wr_push  in  1  load wr_data into the write buffer.
- wr_data  in  32  write word.
- wr_full  out  1  buffer holds BUF_DEPTH words.
- rd_valid  out  1  one-cycle pulse per completed read phase.
- rd_data  out  32  captured AD for that phase.
- done  out  1  one-cycle pulse at end of transaction.
- status  out  2  00 ok, 01 master abort, 10 target stop, 11 TRDY timeout; valid with done.
- words_done  out  4  data phases completed; valid with done.
- AD  inout  32  multiplexed address/data.
- CBEout  out  4  command / byte enables.
- frameout  out  1  FRAME, active low.
- IRDY  out  1  active low.
- TRDY  in  1  active low.
- DEVSEL  in  1  active low.
- stop  in  1  active low.

Behaviour:
- Reset (reset=0, immediate, also mid-transaction):
  - frameout=1, IRDY=1, CBEout=0, AD released (z).
  - req_ready=0 during reset, 1 after; rd_valid=0, done=0, status=00, words_done=0.
  - Buffer count and pointers = 0; FSM = IDLE.
- Write buffer:
  - FIFO, loaded only in IDLE.
  - wr_push when full, or outside IDLE, is ignored.
  - Cleared at every transaction end, so unsent words are discarded.
- req_ready = IDLE && req_len != 0 && (!req_write || wr_count >= req_len).
  - req_len = 0 is never accepted.
  - Request is taken on posedge with req_valid && req_ready; req_addr, req_write, req_be and req_len are latched.
- IDLE -> ADDR on accept.
- ADDR, 1 clock:
  - frameout=0, IRDY=1.
  - AD = addr, CBEout = CMD_WRITE or CMD_READ.
  - Timeout counter cleared. Next state DATA.
- DATA:
  - IRDY=0, CBEout=req_be.
  - Write: AD = buffer[rd_ptr]. Read: AD released.
  - frameout=0 while remaining > 1, frameout=1 while remaining == 1.
  - A phase completes on posedge sampling IRDY=0 && TRDY=0 && DEVSEL=0:
    - Write: rd_ptr++.
    - Read: rd_data <= AD and rd_valid pulses next cycle.
    - words_done++, remaining--.
    - Remaining reaching 0 -> END with status 00.
  - stop=0 sampled with DEVSEL=0:
    - If TRDY=0 in the same edge, that phase still completes.
    - Then go to END, status 10 (unless remaining just hit 0, then status 00).
  - DEVSEL still 1 after DEVSEL_TIMEOUT clocks counted from ADDR -> END, status 01, words_done=0.
  - DEVSEL=0 with TRDY=1 for TRDY_TIMEOUT consecutive clocks -> END, status 11.
  - The TRDY counter resets on each completed phase.
  - Priority on the same edge: completed phase > stop > timeouts.
- END, 1 clock:
  - frameout=1, IRDY=1, AD released, CBEout=0.
  - done pulses with status and words_done.
  - Buffer cleared. Next state IDLE.
- AD is never driven by the initiator in IDLE, END, or read DATA.

Test Plan:
- Push 4 words A0..A3, request write addr 8, len 4, be 1111, target answers DEVSEL/TRDY -> one ADDR clock with CBEout=0111, then 4 completed phases; frameout rises during the 4th; done with status 00, words_done 4.
- Request read addr 9, len 2, target returning 11111111 then 22222222 -> two rd_valid pulses with those values, CBEout=0110 in ADDR, AD z in DATA, status 00.
- Request write len 3 with only 2 words buffered -> req_ready stays 0; after one more wr_push, req_ready=1 and the transfer proceeds.
- Read with DEVSEL held 1 -> 5 clocks after ADDR, END: frameout=1, IRDY=1, status 01, words_done 0.
- Write len 6; target asserts stop=0 with TRDY=0 on phase 3 -> 3 words completed, status 10, buffer empty afterward (wr_full=0, req_ready reflects an empty buffer).
- Reset pulled low mid-DATA of a write -> same clock frameout=1, IRDY=1, AD z, no done pulse; after release req_ready=1 and the buffer is empty.
